segled_scan_ndigit: RTL and testbench

SEGLED_SCAN_NDIGIT -- requirements
Module: segled_scan_ndigit

---
 rtl/segled_pkg.sv | 48 ++++
 rtl/bcd_dabble_seq.sv | 134 +++++++++++++
 rtl/segled_scan_ndigit.sv | 184 ++++++++++++++++++
 tb/tb_segled_scan_ndigit.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/segled_pkg.sv
// Shared types and constants for the multiplexed seven-segment scanner:
// converter state encoding, glyph patterns and the BCD sizing helper.
package segled_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } conv_state_t;

  // Active-high patterns, bit 0 = a .. bit 6 = g
  localparam logic [6:0] GLYPH_0     = 7'h3F;
  localparam logic [6:0] GLYPH_1     = 7'h06;
  localparam logic [6:0] GLYPH_2     = 7'h5B;
  localparam logic [6:0] GLYPH_3     = 7'h4F;
  localparam logic [6:0] GLYPH_4     = 7'h66;
  localparam logic [6:0] GLYPH_5     = 7'h6D;
  localparam logic [6:0] GLYPH_6     = 7'h7D;
  localparam logic [6:0] GLYPH_7     = 7'h07;
  localparam logic [6:0] GLYPH_8     = 7'h7F;
  localparam logic [6:0] GLYPH_9     = 7'h6F;
  localparam logic [6:0] GLYPH_MINUS = 7'h40;
  localparam logic [6:0] GLYPH_BLANK = 7'h00;

  // Decimal digits needed for a data_w-bit unsigned value (1233/4096 ~ log10(2))
  function automatic int bcd_digits(input int data_w);
    return ((data_w * 1233) >> 12) + 1;
  endfunction

  function automatic logic [6:0] glyph_of(input logic [3:0] digit);
    logic [6:0] g;
    case (digit)
      4'd0:    g = GLYPH_0;
      4'd1:    g = GLYPH_1;
      4'd2:    g = GLYPH_2;
      4'd3:    g = GLYPH_3;
      4'd4:    g = GLYPH_4;
      4'd5:    g = GLYPH_5;
      4'd6:    g = GLYPH_6;
      4'd7:    g = GLYPH_7;
      4'd8:    g = GLYPH_8;
      4'd9:    g = GLYPH_9;
      default: g = GLYPH_BLANK;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/bcd_dabble_seq.sv
// Sequential binary-to-BCD converter (double-dabble, one bit per cycle)
// with sign/magnitude capture and a one-cycle commit strobe.
module bcd_dabble_seq
  import segled_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int BCD_W  = 4 * bcd_digits(32)
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_signed,
  output logic              in_ready,
  output logic              commit,
  output logic [BCD_W-1:0]  bcd,
  output logic              neg
);

  localparam int                CNT_W      = $clog2(DATA_W);
  localparam logic [CNT_W-1:0]  LAST_SHIFT = CNT_W'(DATA_W - 1);

  conv_state_t               state_r;
  conv_state_t               state_s;
  logic [CNT_W-1:0]          cnt_r;
  logic [DATA_W-1:0]         bin_r;
  logic [BCD_W-1:0]          bcd_r;
  logic                      neg_r;
  logic                      ready_r;
  logic                      commit_r;
  logic                      neg_in_s;
  logic [DATA_W:0]           mag_s;
  logic [BCD_W-1:0]          adj_s;
  logic [BCD_W+DATA_W-1:0]   shifted_s;

  // Magnitude is one bit wider so the most negative input negates cleanly
  always_comb begin
    neg_in_s = in_signed & in_data[DATA_W-1];
    if (neg_in_s) begin
      mag_s = {1'b0, ~in_data} + {{DATA_W{1'b0}}, 1'b1};
    end else begin
      mag_s = {1'b0, in_data};
    end
  end

  // Add-3 correction on every nibble, then shift the combined register
  always_comb begin
    adj_s = bcd_r;
    for (int i = 0; i < BCD_W / 4; i++) begin
      if (bcd_r[4*i +: 4] >= 4'd5) begin
        adj_s[4*i +: 4] = bcd_r[4*i +: 4] + 4'd3;
      end else begin
        adj_s[4*i +: 4] = bcd_r[4*i +: 4];
      end
    end
    shifted_s = {adj_s, bin_r} << 1;
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          state_s = SHIFT;
        end else begin
          state_s = IDLE;
        end
      end
      SHIFT: begin
        if (cnt_r == LAST_SHIFT) begin
          state_s = COMMIT;
        end else begin
          state_s = SHIFT;
        end
      end
      COMMIT:  state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State register plus flags decoded one cycle early so they are registered
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_r  <= IDLE;
      ready_r  <= 1'b1;
      commit_r <= 1'b0;
    end else begin
      state_r  <= state_s;
      ready_r  <= (state_s == IDLE);
      commit_r <= (state_s == COMMIT);
    end
  end

  // Datapath: load on accept, shift while converting, hold otherwise
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt_r <= '0;
      bin_r <= '0;
      bcd_r <= '0;
      neg_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          cnt_r <= '0;
          if (in_valid) begin
            bin_r <= mag_s[DATA_W-1:0];
            // Bit DATA_W is pre-shifted into the BCD field (never set in practice)
            bcd_r <= {{(BCD_W-1){1'b0}}, mag_s[DATA_W]};
            neg_r <= neg_in_s;
          end else begin
            bin_r <= bin_r;
            bcd_r <= bcd_r;
            neg_r <= neg_r;
          end
        end
        SHIFT: begin
          cnt_r <= cnt_r + CNT_W'(1);
          bcd_r <= shifted_s[BCD_W+DATA_W-1:DATA_W];
          bin_r <= shifted_s[DATA_W-1:0];
        end
        default: begin
          cnt_r <= cnt_r;
        end
      endcase
    end
  end

  assign in_ready = ready_r;
  assign commit   = commit_r;
  assign bcd      = bcd_r;
  assign neg      = neg_r;

endmodule

// File: rtl/segled_scan_ndigit.sv
// N-digit multiplexed seven-segment driver: converts a binary value to
// decimal, applies blanking/sign/overflow rules and scans the digits.
module segled_scan_ndigit
  import segled_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int DATA_W      = 32,
  parameter int SCAN_DIV    = 50000,
  parameter int SEG_ACT_LOW = 1,
  parameter int DIG_ACT_LOW = 1
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic                  in_valid,
  input  logic [DATA_W-1:0]     in_data,
  input  logic                  in_signed,
  output logic                  in_ready,
  input  logic                  blank_en,
  input  logic [NUM_DIGITS-1:0] dp_mask,
  output logic [7:0]            seg,
  output logic [NUM_DIGITS-1:0] dig_sel,
  output logic                  overflow
);

  localparam int BCD_DIGITS = bcd_digits(DATA_W);
  localparam int BCD_W      = 4 * BCD_DIGITS;
  localparam int IDX_W      = $clog2(NUM_DIGITS);
  localparam int PRE_W      = $clog2(SCAN_DIV);

  localparam logic [7:0]            SEG_OFF = (SEG_ACT_LOW != 0) ? 8'hFF : 8'h00;
  localparam logic [NUM_DIGITS-1:0] DIG_OFF = (DIG_ACT_LOW != 0) ? {NUM_DIGITS{1'b1}}
                                                                   : {NUM_DIGITS{1'b0}};
  localparam logic [PRE_W-1:0]      PRE_LAST = PRE_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  logic                  conv_commit_s;
  logic [BCD_W-1:0]      conv_bcd_s;
  logic                  conv_neg_s;

  logic [BCD_W-1:0]      disp_bcd_r;
  logic                  disp_neg_r;
  logic                  disp_ovf_r;
  logic [PRE_W-1:0]      pre_r;
  logic [IDX_W-1:0]      idx_r;

  logic [BCD_W-1:0]      view_bcd_s;
  logic                  view_neg_s;
  int                    cnt_s;
  int                    pos_s;
  logic                  ovf_s;
  logic [3:0]            nib_s;
  logic [6:0]            glyph_s;
  logic [7:0]            seg_raw_s;
  logic [7:0]            seg_next_s;
  logic [NUM_DIGITS-1:0] onehot_s;

  bcd_dabble_seq #(
    .DATA_W (DATA_W),
    .BCD_W  (BCD_W)
  ) u_dabble (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_signed (in_signed),
    .in_ready  (in_ready),
    .commit    (conv_commit_s),
    .bcd       (conv_bcd_s),
    .neg       (conv_neg_s)
  );

  // During COMMIT the fresh result is shown so the output register picks it up
  // on the same edge the display register loads
  always_comb begin
    if (conv_commit_s) begin
      view_bcd_s = conv_bcd_s;
      view_neg_s = conv_neg_s;
    end else begin
      view_bcd_s = disp_bcd_r;
      view_neg_s = disp_neg_r;
    end
  end

  // Significant digit count and fit check
  always_comb begin
    cnt_s = 1;
    for (int i = 1; i < BCD_DIGITS; i++) begin
      if (view_bcd_s[4*i +: 4] != 4'd0) begin
        cnt_s = i + 1;
      end else begin
        cnt_s = cnt_s;
      end
    end
    ovf_s = (cnt_s + (view_neg_s ? 1 : 0)) > NUM_DIGITS;
  end

  // Display register: loads only when the converter commits
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      disp_bcd_r <= '0;
      disp_neg_r <= 1'b0;
      disp_ovf_r <= 1'b0;
    end else if (conv_commit_s) begin
      disp_bcd_r <= conv_bcd_s;
      disp_neg_r <= conv_neg_s;
      disp_ovf_r <= ovf_s;
    end else begin
      disp_bcd_r <= disp_bcd_r;
      disp_neg_r <= disp_neg_r;
      disp_ovf_r <= disp_ovf_r;
    end
  end

  // Slot prescaler and digit index
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      pre_r <= '0;
      idx_r <= '0;
    end else if (pre_r == PRE_LAST) begin
      pre_r <= '0;
      idx_r <= (idx_r == IDX_LAST) ? '0 : idx_r + IDX_W'(1);
    end else begin
      pre_r <= pre_r + PRE_W'(1);
      idx_r <= idx_r;
    end
  end

  // Glyph for the digit currently being scanned
  always_comb begin
    pos_s = int'(idx_r);
    nib_s = 4'd0;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (i == pos_s) begin
        nib_s = view_bcd_s[4*i +: 4];
      end else begin
        nib_s = nib_s;
      end
    end
    glyph_s = GLYPH_BLANK;
    if (blank_en) begin
      if (pos_s < cnt_s) begin
        glyph_s = glyph_of(nib_s);
      end else if (view_neg_s && (pos_s == cnt_s)) begin
        glyph_s = GLYPH_MINUS;
      end else begin
        glyph_s = GLYPH_BLANK;
      end
    end else begin
      if (view_neg_s && (pos_s == NUM_DIGITS - 1)) begin
        glyph_s = GLYPH_MINUS;
      end else begin
        glyph_s = glyph_of(nib_s);
      end
    end
    if (ovf_s) begin
      seg_raw_s = {1'b0, GLYPH_MINUS};
    end else begin
      seg_raw_s = {dp_mask[idx_r], glyph_s};
    end
  end

  // Dark on the first cycle of each slot to avoid ghosting across digits
  always_comb begin
    seg_next_s = (pre_r == '0) ? 8'h00 : seg_raw_s;
    onehot_s   = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      onehot_s[i] = (pos_s == i);
    end
  end

  // Output registers, polarity applied here only
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      seg     <= SEG_OFF;
      dig_sel <= DIG_OFF;
    end else begin
      seg     <= seg_next_s ^ SEG_OFF;
      dig_sel <= onehot_s ^ DIG_OFF;
    end
  end

  assign overflow = disp_ovf_r;

endmodule

// File: tb/tb_segled_scan_ndigit.sv
// Scoreboard bench: stimulus queues the committed value, a monitor compares
// every scanned cycle against a decimal-string reference model.
module tb_segled_scan_ndigit;

  localparam int N   = 4;
  localparam int DW  = 32;
  localparam int DIV = 4;

  logic          sys_clk;
  logic          sys_rst_n;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_signed;
  logic          in_ready;
  logic          blank_en;
  logic [N-1:0]  dp_mask;
  logic [7:0]    seg;
  logic [N-1:0]  dig_sel;
  logic          overflow;

  int     n_checks = 0;
  int     n_pass   = 0;
  longint exp_q[$];

  logic [6:0] glyph_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  segled_scan_ndigit #(
    .NUM_DIGITS  (N),
    .DATA_W      (DW),
    .SCAN_DIV    (DIV),
    .SEG_ACT_LOW (1),
    .DIG_ACT_LOW (1)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_signed (in_signed),
    .in_ready  (in_ready),
    .blank_en  (blank_en),
    .dp_mask   (dp_mask),
    .seg       (seg),
    .dig_sel   (dig_sel),
    .overflow  (overflow)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic longint model_val(input logic [31:0] d, input logic s);
    logic signed [31:0] ds;
    ds = d;
    if (s) return longint'(ds);
    return longint'({32'd0, d});
  endfunction

  function automatic int num_dec(input longint v);
    longint mag;
    int k;
    mag = (v < 0) ? -v : v;
    k = 0;
    do begin
      k++;
      mag = mag / 10;
    end while (mag > 0);
    return k;
  endfunction

  function automatic bit too_wide(input longint v);
    return (num_dec(v) + ((v < 0) ? 1 : 0)) > N;
  endfunction

  // Text rendering: right-justified decimal, optional zero padding, then glyph
  function automatic logic [7:0] exp_seg(input longint v, input logic b,
                                         input logic [N-1:0] m, input int p);
    longint mag;
    int d[$];
    int ch;
    logic [6:0] g;
    bit neg;
    neg = (v < 0);
    mag = neg ? -v : v;
    do begin
      d.push_back(int'(mag % 10));
      mag = mag / 10;
    end while (mag > 0);
    if (too_wide(v)) return ~8'h40;
    if (p < d.size()) ch = d[p];
    else if (b) ch = (neg && p == d.size()) ? -2 : -1;
    else ch = (neg && p == N - 1) ? -2 : 0;
    if (ch >= 0) g = glyph_tab[ch];
    else if (ch == -2) g = 7'h40;
    else g = 7'h00;
    return ~{m[p], g};
  endfunction

  // Monitor: independent scan model plus display contents from the queue
  initial begin : monitor
    longint cur_v;
    int dig, pos, low_cnt;
    logic prev_ready;
    bit after_rst;
    logic [N-1:0] exp_dig;
    logic [7:0] exp_s;
    cur_v = 0; dig = 0; pos = 0; low_cnt = 0; prev_ready = 1'b1; after_rst = 1'b0;
    forever begin
      @(posedge sys_clk);
      #1;
      if (!sys_rst_n) begin
        exp_q.delete();
        cur_v = 0; dig = 0; pos = 0; low_cnt = 0; prev_ready = 1'b1; after_rst = 1'b1;
        check("rst_seg", seg, 8'hFF);
        check("rst_dig_sel", dig_sel, 4'hF);
        check("rst_overflow", overflow, 0);
      end else begin
        if (after_rst) begin
          check("ready_after_rst", in_ready, 1);
          after_rst = 1'b0;
        end
        if (!in_ready) begin
          low_cnt++;
        end else if (!prev_ready) begin
          check("busy_cycles", low_cnt, DW + 1);
          low_cnt = 0;
          check("commit_queued", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) cur_v = exp_q.pop_front();
        end
        prev_ready = in_ready;
        exp_dig = ~(4'b0001 << dig);
        exp_s = (pos == 0) ? 8'hFF : exp_seg(cur_v, blank_en, dp_mask, dig);
        check("dig_sel", dig_sel, exp_dig);
        check("seg", seg, exp_s);
        check("overflow", overflow, too_wide(cur_v));
        pos++;
        if (pos == DIV) begin
          pos = 0;
          dig = (dig + 1) % N;
        end
      end
    end
  end

  task automatic wait_ready();
    int t;
    t = 0;
    while (!in_ready && t < 200) begin
      @(negedge sys_clk);
      t++;
    end
    if (!in_ready) check("ready_timeout", in_ready, 1);
  endtask

  task automatic issue(input logic [31:0] d, input logic s, input logic b,
                       input logic [N-1:0] m);
    @(negedge sys_clk);
    wait_ready();
    in_data = d; in_signed = s; blank_en = b; dp_mask = m; in_valid = 1'b1;
    exp_q.push_back(model_val(d, s));
    @(negedge sys_clk);
    in_valid = 1'b0;
    in_data = $urandom;
    wait_ready();
    repeat (20) @(negedge sys_clk);
  endtask

  initial begin : stimulus
    int last_acc, nacc, cyc;
    logic [31:0] d;
    sys_rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_signed = 1'b0;
    blank_en = 1'b1; dp_mask = '0;
    repeat (3) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    repeat (20) @(negedge sys_clk);

    issue(32'd1234, 1'b0, 1'b1, 4'b0000);
    issue(-32'sd12, 1'b1, 1'b1, 4'b0000);
    issue(-32'sd12, 1'b1, 1'b0, 4'b0100);
    issue(-32'sd1234, 1'b1, 1'b1, 4'b1111);
    issue(32'h8000_0000, 1'b1, 1'b1, 4'b0000);
    issue(32'h8000_0000, 1'b0, 1'b0, 4'b0000);
    issue(32'd0, 1'b0, 1'b1, 4'b0001);
    issue(32'd9999, 1'b0, 1'b0, 4'b1010);
    issue(32'd10000, 1'b0, 1'b1, 4'b0000);
    issue(-32'sd999, 1'b1, 1'b1, 4'b0010);
    issue(32'hFFFF_FFFF, 1'b0, 1'b1, 4'b0000);
    issue(32'd7, 1'b0, 1'b0, 4'b0000);

    for (int i = 0; i < 24; i++) begin
      case ($urandom_range(0, 3))
        0: d = $urandom_range(0, 9999);
        1: d = -$urandom_range(1, 999);
        2: d = $urandom_range(0, 99);
        default: d = $urandom;
      endcase
      issue(d, 1'(($urandom_range(0, 1))), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
    end

    // in_valid held high with changing data: only values seen while ready count
    blank_en = 1'b1; dp_mask = 4'b0000;
    last_acc = -1; nacc = 0; cyc = 0;
    while (nacc < 3 && cyc < 300) begin
      @(negedge sys_clk);
      cyc++;
      in_valid = 1'b1;
      in_data = $urandom_range(0, 9999);
      in_signed = 1'($urandom_range(0, 1));
      if (in_ready) begin
        exp_q.push_back(model_val(in_data, in_signed));
        if (last_acc >= 0) check("accept_spacing", cyc - last_acc, DW + 2);
        last_acc = cyc;
        nacc++;
      end
    end
    check("held_accepts", nacc, 3);
    @(negedge sys_clk);
    in_valid = 1'b0;
    wait_ready();
    repeat (20) @(negedge sys_clk);

    // Reset during conversion: nothing may commit afterwards
    issue(32'd42, 1'b0, 1'b1, 4'b0000);
    @(negedge sys_clk);
    in_data = 32'd5678; in_signed = 1'b0; in_valid = 1'b1;
    exp_q.push_back(model_val(in_data, in_signed));
    @(negedge sys_clk);
    in_valid = 1'b0;
    repeat (10) @(negedge sys_clk);
    sys_rst_n = 1'b0;
    repeat (2) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    repeat (60) @(negedge sys_clk);
    issue(32'd31, 1'b0, 1'b1, 4'b0000);

    check("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
